fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//   Pointer/flag controller driving the 16x8 synchronous FIFO storage array. Converts
//   wr_req/rd_req handshakes into en_write/en_read and ptr_in/ptr_out for the array,
//   tracks occupancy, and raises full/empty/almost/error flags. Marks the storage's
//   registered read data valid one cycle after an accepted read.
// PARAMETERS
//   ADDR_W     4   storage address bits; DEPTH = 2**ADDR_W = 16 entries
//   AF_THRESH  12  almost_full asserted when count >= AF_THRESH
//   AE_THRESH  4   almost_empty asserted when count <= AE_THRESH
// PORTS
//   clk           in   1         clock, all state updates on rising edge
//   reset         in   1         synchronous, active-high
//   wr_req        in   1         producer requests a write this cycle
//   rd_req        in   1         consumer requests a read this cycle
//   flush         in   1         synchronous discard of all contents
//   clr_err       in   1         clears sticky overflow/underflow
//   ptr_in        out  ADDR_W+1  write address to storage; MSB always 0
//   ptr_out       out  ADDR_W+1  read address to storage; MSB always 0
//   en_write      out  1         write strobe to storage
//   en_read       out  1         read strobe to storage
//   rd_valid      out  1         storage data_out holds valid read data this cycle
//   count         out  ADDR_W+1  occupancy, 0..DEPTH
//   full/empty    out  1 each    count==DEPTH / count==0
//   almost_full   out  1         count >= AF_THRESH
//   almost_empty  out  1         count <= AE_THRESH
//   overflow      out  1         sticky: write requested while full
//   underflow     out  1         sticky: read requested while empty
// BEHAVIOUR
//   - Reset: wr_ptr=rd_ptr=0, count=0, state EMPTY, rd_valid=0, overflow=underflow=0;
//     outputs: en_write=en_read=0, ptr_in=ptr_out=0, empty=1, almost_empty=1, rest 0.
//   - Internal wr_ptr/rd_ptr are ADDR_W+1 bits (wrap bit); ptr_in/ptr_out = {0, ptr[ADDR_W-1:0]}
//     so the storage index never exceeds DEPTH-1.
//   - wr_acc = wr_req & ~full & ~flush; rd_acc = rd_req & ~empty & ~flush (combinational).
//   - en_write = wr_acc, en_read = rd_acc, same cycle as request; storage captures on that edge.
//   - On edge: wr_acc -> wr_ptr+1; rd_acc -> rd_ptr+1; count += wr_acc - rd_acc (both -> unchanged).
//   - Pointers wrap modulo 2*DEPTH; full when addr bits equal and wrap bits differ.
//   - Read latency 1: rd_valid registered = rd_acc; data valid on data_out the following cycle.
//   - Simultaneous wr/rd when full: read accepted, write rejected, overflow set.
//   - Simultaneous wr/rd when empty: write accepted, read rejected (no bypass), underflow set.
//   - overflow <= 1 on wr_req&full&~flush; underflow <= 1 on rd_req&empty&~flush; cleared
//     only by reset or clr_err (set wins over clr_err in same cycle).
//   - FSM states EMPTY, PARTIAL, FULL (registered; flags decoded from state/count):
//     EMPTY->PARTIAL on wr_acc&~rd_acc; PARTIAL->EMPTY when count==1 & rd_acc & ~wr_acc;
//     PARTIAL->FULL when count==DEPTH-1 & wr_acc & ~rd_acc; FULL->PARTIAL on rd_acc.
//   - flush: highest priority after reset; next cycle pointers=0, count=0, state EMPTY,
//     rd_valid=0; sticky errors unaffected; no strobes issued during flush cycle.
//   - Reset mid-operation discards contents; rd_valid for an in-flight read forced 0.
// TESTING
//   - Reset, then 16 writes 0x01..0x10 -> full=1 after 16th, count=16, ptr_in wraps to 0.
//   - 17th write while full -> en_write=0, overflow=1, count stays 16; clr_err -> overflow=0.
//   - 16 reads after fill -> rd_valid 1 cycle after each en_read, data 0x01..0x10 in order, empty=1.
//   - rd_req on empty with wr_req -> write accepted, en_read=0, underflow=1, count=1.
//   - count=8, wr_req&rd_req together for 20 cycles -> count stays 8, pointers wrap, no errors.
//   - count=10, assert flush -> next cycle count=0, empty=1, ptr_in=ptr_out=0, rd_valid=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_ctrl : pointer, occupancy and flag controller for a 2**ADDR_W entry
//             synchronous FIFO storage array with 1-cycle registered read data.
// Revision  : 1.0  initial release
// ============================================================================
module fifo_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              flush,
  input  logic              clr_err,
  output logic [ADDR_W:0]   ptr_in,
  output logic [ADDR_W:0]   ptr_out,
  output logic              en_write,
  output logic              en_read,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_ZERO  = '0;
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] C_AE    = (ADDR_W+1)'(AE_THRESH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_acc, rd_acc;

  assign full  = (state_q == ST_FULL);
  assign empty = (state_q == ST_EMPTY);

  // Strobes are suppressed while reset is high so the array never sees a
  // write or read on the edge that discards its contents.
  assign wr_acc = wr_req & ~full  & ~flush & ~reset;
  assign rd_acc = rd_req & ~empty & ~flush & ~reset;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = (wr_req & full & ~flush)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_req & empty & ~flush) | (underflow_q & ~clr_err);

    if (flush) begin
      state_d    = ST_EMPTY;
      wr_ptr_d   = C_ZERO;
      rd_ptr_d   = C_ZERO;
      count_d    = C_ZERO;
      rd_valid_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + C_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + C_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
      case (state_q)
        ST_EMPTY: begin
          if (wr_acc && !rd_acc) state_d = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if ((count_q == C_ONE) && rd_acc && !wr_acc)
            state_d = ST_EMPTY;
          else if ((count_q == (C_DEPTH - C_ONE)) && wr_acc && !rd_acc)
            state_d = ST_FULL;
        end
        ST_FULL: begin
          if (rd_acc) state_d = ST_PARTIAL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= C_ZERO;
      rd_ptr_q    <= C_ZERO;
      count_q     <= C_ZERO;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Wrap bit stays internal; the array only ever sees an index below DEPTH.
  assign ptr_in       = {1'b0, wr_ptr_q[ADDR_W-1:0]};
  assign ptr_out      = {1'b0, rd_ptr_q[ADDR_W-1:0]};
  assign en_write     = wr_acc;
  assign en_read      = rd_acc;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= C_AF);
  assign almost_empty = (count_q <= C_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_ctrl : scoreboard bench for fifo_ctrl with a queue-based FIFO model
// Revision     : 1.0  initial release
// ============================================================================
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset, wr_req, rd_req, flush, clr_err;
  logic [4:0] ptr_in, ptr_out, count;
  logic       en_write, en_read, rd_valid;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [7:0] wdata, dout;
  logic [7:0] mem [16];

  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;

  int         m_cnt = 0, m_wr = 0, m_rd = 0;
  bit         m_ovf = 0, m_udf = 0, m_rdv = 0;
  logic [7:0] m_fifo[$];
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  fifo_ctrl #(.ADDR_W(4), .AF_THRESH(12), .AE_THRESH(4)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
    .flush(flush), .clr_err(clr_err), .ptr_in(ptr_in), .ptr_out(ptr_out),
    .en_write(en_write), .en_read(en_read), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  // Storage array the controller drives: registered read data.
  always @(posedge clk) begin
    if (en_write === 1'b1) mem[ptr_in[3:0]] <= wdata;
    if (en_read === 1'b1)  dout <= mem[ptr_out[3:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_data @%0t: rd_valid with no read outstanding", $time);
      end else begin
        chk("rd_data", 32'(dout), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic step(input bit w, input bit r, input bit f, input bit c,
                      input bit rs, input logic [7:0] d);
    bit exp_wa, exp_ra, nov, nud;
    wr_req = w; rd_req = r; flush = f; clr_err = c; reset = rs; wdata = d;
    exp_wa = w && (m_cnt < 16) && !f && !rs;
    exp_ra = r && (m_cnt > 0)  && !f && !rs;
    @(negedge clk);
    if (chk_en) begin
      chk("en_write",     32'(en_write),     32'(exp_wa));
      chk("en_read",      32'(en_read),      32'(exp_ra));
      chk("ptr_in",       32'(ptr_in),       32'(m_wr));
      chk("ptr_out",      32'(ptr_out),      32'(m_rd));
      chk("count",        32'(count),        32'(m_cnt));
      chk("full",         32'(full),         32'(m_cnt == 16));
      chk("empty",        32'(empty),        32'(m_cnt == 0));
      chk("almost_full",  32'(almost_full),  32'(m_cnt >= 12));
      chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 4));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_udf));
      chk("rd_valid",     32'(rd_valid),     32'(m_rdv));
    end
    @(posedge clk);
    if (rs) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_rdv = 0;
      m_fifo.delete();
    end else begin
      nov = (w && m_cnt == 16 && !f) || (m_ovf && !c);
      nud = (r && m_cnt == 0  && !f) || (m_udf && !c);
      if (f) begin
        m_wr = 0; m_rd = 0; m_rdv = 0;
        m_fifo.delete();
      end else begin
        if (exp_ra) begin
          sb_q.push_back(m_fifo.pop_front());
          m_rd = (m_rd + 1) % 16;
        end
        if (exp_wa) begin
          m_fifo.push_back(d);
          m_wr = (m_wr + 1) % 16;
        end
        m_rdv = exp_ra;
      end
      m_cnt = m_fifo.size();
      m_ovf = nov;
      m_udf = nud;
    end
    #1;
  endtask

  initial begin
    bit w, r;
    step(0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00);
    chk_en = 1'b1;
    step(0, 0, 0, 0, 0, 8'h00);

    // Fill, then one write too many, then clear the sticky error.
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 0, 8'(i));
    step(1, 0, 0, 0, 0, 8'hEE);
    step(0, 0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);

    // Drain everything back out in order.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);

    // Write and read together on empty: write wins, underflow flagged.
    step(1, 1, 0, 0, 0, 8'hA5);
    step(0, 0, 0, 1, 0, 8'h00);

    // Steady-state streaming at count 8 across pointer wrap.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 8'(8'h50 + i));

    // Flush at count 10.
    step(1, 0, 0, 0, 0, 8'h71);
    step(1, 0, 0, 0, 0, 8'h72);
    step(1, 1, 1, 0, 0, 8'h73);
    step(0, 0, 0, 0, 0, 8'h00);

    // Randomised traffic with alternating fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      if ((i / 100) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      step(w, r, ($urandom_range(0, 40) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 149) == 0), 8'($urandom));
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'h00);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
